// File: rtl/param_deserializer.sv
// Serial-to-parallel converter: assembles DATA_WIDTH-bit words from a 1-bit stream
// and queues completed words in a BUF_DEPTH-entry buffer with flush and sticky overflow.
module param_deserializer #(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_DEPTH  = 2,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                               clock_100KHZ,
    input  logic                               reset,
    input  logic                               data_in,
    input  logic                               write_in,
    input  logic                               flush_in,
    input  logic                               ack_in,
    output logic                               status_out,
    output logic [DATA_WIDTH-1:0]              data_out,
    output logic                               data_ready,
    output logic [$clog2(DATA_WIDTH+1)-1:0]    bit_count,
    output logic [$clog2(BUF_DEPTH+1)-1:0]     word_count,
    output logic                               overflow_out
);
    localparam int BCW = $clog2(DATA_WIDTH+1);
    localparam int WCW = $clog2(BUF_DEPTH+1);
    localparam int PW  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    logic [DATA_WIDTH-1:0] sr_q, sr_d, shifted;
    logic [BCW-1:0]        bc_q, bc_d;
    logic [WCW-1:0]        wc_q, wc_d;
    logic [PW-1:0]         wr_q, wr_d, rd_q, rd_d;
    logic                  ovf_q, ovf_d;
    logic [DATA_WIDTH-1:0] buf_q [BUF_DEPTH];
    logic                  accept, push, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    // RECEIVE/STALL is implied by word_count: STALL exactly when the buffer is full.
    assign status_out   = (wc_q < WCW'(BUF_DEPTH));
    assign data_ready   = (wc_q != '0);
    assign data_out     = data_ready ? buf_q[rd_q] : '0;
    assign bit_count    = bc_q;
    assign word_count   = wc_q;
    assign overflow_out = ovf_q;

    assign accept = write_in && status_out && !flush_in;
    assign push   = accept && (bc_q == BCW'(DATA_WIDTH-1));
    assign pop    = ack_in && data_ready;

    always_comb begin
        if (MSB_FIRST) shifted = {sr_q[DATA_WIDTH-2:0], data_in};
        else           shifted = {data_in, sr_q[DATA_WIDTH-1:1]};
    end

    always_comb begin
        sr_d  = sr_q;
        bc_d  = bc_q;
        wc_d  = wc_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        // A flushed write is discarded deliberately, so it never counts as overflow.
        ovf_d = ovf_q | (write_in && !status_out && !flush_in);
        if (flush_in) begin
            sr_d = '0;
            bc_d = '0;
        end else if (accept) begin
            sr_d = shifted;
            bc_d = push ? '0 : bc_q + 1'b1;
        end
        if (push) wr_d = ptr_inc(wr_q);
        if (pop)  rd_d = ptr_inc(rd_q);
        case ({push, pop})
            2'b10:   wc_d = wc_q + 1'b1;
            2'b01:   wc_d = wc_q - 1'b1;
            default: wc_d = wc_q;
        endcase
    end

    always_ff @(posedge clock_100KHZ) begin
        if (!reset) begin
            sr_q  <= '0;
            bc_q  <= '0;
            wc_q  <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            sr_q  <= sr_d;
            bc_q  <= bc_d;
            wc_q  <= wc_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            ovf_q <= ovf_d;
        end
    end

    // Storage needs no reset: data_out is masked while word_count is zero.
    always_ff @(posedge clock_100KHZ) begin
        if (reset && push) buf_q[wr_q] <= shifted;
    end
endmodule
